// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the wait-stated memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;

  localparam logic ERR_NONE  = 1'b0;
  localparam logic ERR_FAULT = 1'b1;

  // Full word index of a byte address; callers zero-extend to 64 bits.
  function automatic logic [61:0] word_index(input logic [63:0] addr);
    return addr[63:2];
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter that times the wait states of one request.
module mem_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic       o_done
);

  logic [3:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  // A zero load value finishes immediately so the FSM can skip WAIT.
  assign o_done = i_load ? (i_load_val == 4'd0) : (r_count == 4'd1);

endmodule

// File: rtl/mem_responder.sv
// Wait-stated word memory with ready/err handshake for the multi-cycle datapath.
// Define MEM_STATS_EN to add saturating rd_count/wr_count statistics ports.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [WORD_W-1:0] writeData,
  output logic [WORD_W-1:0] ReadData,
  output logic              ready,
  output logic              err
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t              r_state;
  state_t              w_next;
  logic                r_rd;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_rdata;
  logic [WORD_W-1:0]   r_mem [DEPTH];

  logic                w_req;
  logic                w_load;
  logic                w_en;
  logic                w_done;
  logic                w_in_resp;
  logic [61:0]         w_widx;
  logic [IDX_W-1:0]    w_idx;
  logic                w_both;
  logic                w_misal;
  logic                w_oor;
  logic                w_fault;
  logic                w_rd_upd;
  logic                w_good_wr;
  logic [WORD_W-1:0]   w_rd_val;

  assign w_req     = MemRead | MemWrite;
  assign w_load    = (r_state == IDLE) & w_req;
  assign w_en      = (r_state == WAIT) & w_req;
  assign w_in_resp = (r_state == RESP);

  mem_wait_counter u_wait (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_load),
    .i_load_val (WAIT_LD),
    .i_en       (w_en),
    .o_done     (w_done)
  );

  // Fault classification works only on the request captured at acceptance.
  assign w_widx  = word_index(64'(r_addr));
  assign w_idx   = r_addr[2 +: IDX_W];
  assign w_both  = r_rd & r_wr;
  assign w_misal = (r_addr[1:0] != 2'b00);
  assign w_oor   = (w_widx >= 62'(DEPTH));
  assign w_fault = w_both | w_misal | w_oor;

  assign w_rd_upd  = w_in_resp & r_rd & ~r_wr & ~w_misal;
  assign w_good_wr = w_in_resp & r_wr & ~r_rd & ~w_misal & ~w_oor;
  assign w_rd_val  = w_oor ? '0 : r_mem[w_idx];

  assign ReadData = w_rd_upd ? w_rd_val : r_rdata;
  assign ready    = w_in_resp;
  assign err      = (w_in_resp && w_fault) ? ERR_FAULT : ERR_NONE;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_req) w_next = w_done ? RESP : WAIT;
      end
      WAIT: begin
        if (!w_req)      w_next = IDLE;
        else if (w_done) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_rd   <= MemRead;
        r_wr   <= MemWrite;
        r_addr <= Address;
      end
      if (w_rd_upd) r_rdata <= w_rd_val;
    end
  end

  // Writes commit at the end of RESP, so writeData is taken from that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_good_wr) begin
      r_mem[w_idx] <= writeData;
    end
  end

`ifdef MEM_STATS_EN
  logic        w_good_rd;
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  assign w_good_rd = w_rd_upd & ~w_oor;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_good_rd && (r_rd_cnt != 32'hFFFF_FFFF)) r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_good_wr && (r_wr_cnt != 32'hFFFF_FFFF)) r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end

  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;
`endif

endmodule
